// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_pkg
// Purpose  : Shared state encoding and result-select codes for the
//            floating-point multiplier sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package fpmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_MUL_WAIT = 3'd2,
        ST_RND_WAIT = 3'd3,
        ST_RESULT   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_COMPUTED = 2'b00;
    localparam logic [1:0] SEL_ZERO     = 2'b01;
    localparam logic [1:0] SEL_INF      = 2'b10;
    localparam logic [1:0] SEL_NAN      = 2'b11;

    localparam int c_default_timeout_cycles = 64;

endpackage
`default_nettype wire

// File: rtl/fpmul_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_watchdog
// Purpose  : Saturating wait-cycle counter; expired marks the last allowed
//            cycle of a multiply or rounding wait.
// Revision : 1.0 - initial release
// ============================================================================
module fpmul_watchdog
    import fpmul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_default_timeout_cycles,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_max   = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/fpmul_controller.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_controller
// Purpose  : Req/Ack sequencer for the FP multiplier datapath, with result
//            class selection and a watchdog that turns hangs into NaN.
// Revision : 1.0 - initial release
// ============================================================================
module fpmul_controller
    import fpmul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_default_timeout_cycles,
    parameter int CNT_W          = 7
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Req,
    input  logic       Equal,
    input  logic       Over1,
    input  logic       DoneO,
    input  logic       Over2,
    input  logic       DoneR,
    output logic       Start,
    output logic       StartR,
    output logic [1:0] S,
    output logic       DONE,
    output logic       Ack,
    output logic       Busy,
    output logic       Timeout
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_sel;
    logic [1:0] w_sel_next;
    logic       r_timeout;
    logic       w_timeout_next;
    logic       w_wd_clear;
    logic       w_wd_enable;
    logic       w_wd_expired;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_sel     <= SEL_COMPUTED;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_timeout_next = r_timeout;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    w_state_next   = ST_LAUNCH;
                    w_timeout_next = 1'b0;
                end
            end
            ST_LAUNCH: begin
                if (Equal) begin
                    w_state_next = ST_RESULT;
                    w_sel_next   = SEL_ZERO;
                end else if (Over1) begin
                    w_state_next = ST_RESULT;
                    w_sel_next   = SEL_INF;
                end else begin
                    w_state_next = ST_MUL_WAIT;
                end
            end
            ST_MUL_WAIT: begin
                // completion beats the watchdog on the same cycle
                if (DoneO) begin
                    w_state_next = ST_RND_WAIT;
                end else if (w_wd_expired) begin
                    w_state_next   = ST_RESULT;
                    w_sel_next     = SEL_NAN;
                    w_timeout_next = 1'b1;
                end
            end
            ST_RND_WAIT: begin
                if (DoneR) begin
                    w_state_next = ST_RESULT;
                    w_sel_next   = Over2 ? SEL_INF : SEL_COMPUTED;
                end else if (w_wd_expired) begin
                    w_state_next   = ST_RESULT;
                    w_sel_next     = SEL_NAN;
                    w_timeout_next = 1'b1;
                end
            end
            ST_RESULT: begin
                if (!Req) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Any state change restarts the wait count from zero.
    assign w_wd_clear  = (w_state_next != r_state);
    assign w_wd_enable = (r_state == ST_MUL_WAIT) || (r_state == ST_RND_WAIT);

    fpmul_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (CLK),
        .rst       (Reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    assign Start   = (r_state == ST_LAUNCH) || (r_state == ST_MUL_WAIT);
    assign StartR  = (r_state == ST_RND_WAIT);
    assign DONE    = (r_state == ST_RESULT);
    assign Ack     = (r_state == ST_RESULT);
    assign Busy    = (r_state != ST_IDLE);
    assign S       = r_sel;
    assign Timeout = r_timeout;

endmodule
`default_nettype wire

// File: doc/fpmul_controller.md
Name: fpmul_controller

Overview:
Sequencing FSM for the single-precision floating-point multiplier datapath. It accepts a four-phase Req/Ack transaction from a requester and drives the datapath strobes Start and StartR. It consumes the datapath status flags Equal, Over1, DoneO, Over2 and DoneR, selects the result class on the S mux, and enables the tri-state output via DONE. A watchdog converts a hung multiply or rounding step into a NaN result.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent waiting in MUL_WAIT or in RND_WAIT before aborting.
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLK  input  1  clock, rising edge.
Reset  input  1  synchronous, active-high reset.
Req  input  1  requester asks for a multiply; operands are stable while Req=1.
Equal  input  1  special-operand flag from the datapath (zero operand, so the result is zero).
Over1  input  1  exponent-add overflow from the datapath.
DoneO  input  1  mantissa multiply complete.
Over2  input  1  overflow produced by rounding/normalisation.
DoneR  input  1  rounding complete.
Start  output  1  launches the comparator, exponent register and mantissa multiply.
StartR  output  1  enables rounding.
S  output  2  result select: 00 computed, 01 zero, 10 infinity, 11 NaN.
DONE  output  1  output enable for the result bus.
Ack  output  1  transaction-complete acknowledge.
Busy  output  1  high in every state except IDLE.
Timeout  output  1  sticky flag for the current result; set when the watchdog aborts.

Behaviour:
- Clock and reset: single clock CLK; Reset is synchronous and active-high.
- Reset: next edge forces IDLE. Start=0, StartR=0, S=00, DONE=0, Ack=0, Busy=0, Timeout=0, counter=0. This applies in any state, including mid-operation.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational paths.
- States: IDLE, LAUNCH, MUL_WAIT, RND_WAIT, RESULT.
- IDLE: if Req=1, go to LAUNCH and clear Timeout.
- LAUNCH (exactly 1 cycle): Start=1. Equal and Over1 are sampled at the end of this cycle.
  - Equal=1: go to RESULT with S=01. Equal has priority over Over1.
  - Otherwise Over1=1: go to RESULT with S=10.
  - Otherwise: go to MUL_WAIT with counter=0.
- MUL_WAIT: Start=1 is held, because the multiply enable counter runs on the Start level.
  - DoneO=1: go to RND_WAIT with counter=0.
  - Counter reaches TIMEOUT_CYCLES-1 without DoneO: go to RESULT with S=11 and Timeout=1.
  - DoneO on the same cycle as the timeout: DoneO wins.
- RND_WAIT: Start=0, StartR=1 held.
  - DoneR=1: sample Over2 in that same cycle. S=10 if Over2=1, else S=00. Go to RESULT.
  - Timeout rule is identical to MUL_WAIT (S=11, Timeout=1). DoneR wins a tie.
- RESULT: DONE=1, Ack=1, Start=0, StartR=0.
  - S and Timeout stay stable for the whole of RESULT.
  - Leave for IDLE when Req=0 (four-phase handshake). DONE and Ack drop on the next edge.
- S retains its value in IDLE and is only updated when RESULT is entered.
- Minimum latency from Req to Ack:
  - Special case (zero or exponent overflow): 2 cycles.
  - Normal path: 2 + (cycles to DoneO) + (cycles to DoneR) + 1.
- Req falling before RESULT: ignored. The operation completes and RESULT exits immediately on the following cycle (Ack is a single pulse).
- Spurious DoneO in RND_WAIT, and DoneR/Over2 in MUL_WAIT: ignored.
- Counter saturates and never wraps. It is cleared on every state entry.

Decomposition:
- Shared package fpmul_pkg:
  - State enum.
  - Result-select constants SEL_COMPUTED=2'b00, SEL_ZERO=2'b01, SEL_INF=2'b10, SEL_NAN=2'b11.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, fpmul_watchdog: a CNT_W-bit counter with clear and enable inputs and an expired output, equal to (count == TIMEOUT_CYCLES-1).
- The FSM and S/Timeout registers stay in the top level.

Test Plan:
- Normal path: Req=1; DoneO asserted 24 cycles after LAUNCH; DoneR 2 cycles after that with Over2=0 -> S=00, DONE=Ack=1 exactly 1 cycle after DoneR. Drop Req -> IDLE and Busy=0 next cycle. With the full datapath, 0x3FC00000 x 0x40000000 gives Out=0x40400000.
- Special operand: Equal=1 and Over1=1 together during LAUNCH -> S=01, Ack on cycle 2, Start high for exactly 1 cycle, StartR never asserted.
- Overflow: Over1=1 in LAUNCH -> S=10. Separately, Over2=1 coincident with DoneR -> S=10.
- Watchdog: DoneO never arrives -> RESULT after exactly 64 MUL_WAIT cycles with S=11 and Timeout=1. Repeat with DoneO on cycle 64 -> normal path taken, Timeout=0.
- Reset mid-operation: assert Reset in RND_WAIT -> all outputs at reset values next edge. A fresh Req then completes normally.
- Back-to-back: hold Req high through RESULT for 5 cycles -> Ack stays high, no relaunch. Req low for 1 cycle then high -> new LAUNCH, previous S held until the new RESULT.
